// File: rtl/mips32_dbg_pkg.sv
// rtl/mips32_dbg_pkg.sv - shared encodings and state type for the MIPS32 debug loader
package mips32_dbg_pkg;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_DUMP  = 2'b10;
    localparam logic [1:0] CMD_NOP   = 2'b11;

    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_INIT,
        ST_RUNNING,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DUMP_OUT
    } state_t;

endpackage

// File: rtl/mips32_dbg_watchdog.sv
// rtl/mips32_dbg_watchdog.sv - run-length watchdog counter with clear/enable/expire
module mips32_dbg_watchdog #(
    parameter int WDOG_CYCLES = 1024,
    parameter int CW          = $clog2(WDOG_CYCLES + 1)
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          expire
);

    assign expire = enable && (count == CW'(WDOG_CYCLES - 1));

    // Saturates at the expiry value so a stuck enable can never wrap to zero.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips32_debug_loader.sv
// rtl/mips32_debug_loader.sv - host loader, run control and register dump engine for the MIPS32 core
module mips32_debug_loader
    import mips32_dbg_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int REG_AW      = 5,
    parameter int NUM_DUMP    = 6,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              proc_init,
    output logic              proc_en,
    input  logic              halted,
    output logic [REG_AW-1:0] reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [REG_AW-1:0] dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              timeout
);

    localparam int              WCW      = $clog2(WDOG_CYCLES + 1);
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_DUMP - 1);

    state_t            state, state_nxt;
    logic [REG_AW-1:0] idx;
    logic [WCW-1:0]    wdog_count;
    logic              wdog_expire;
    logic              halt_seen;

    mips32_dbg_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .CW          (WCW)
    ) u_watchdog (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .clear  (state == ST_INIT),
        .enable (state == ST_RUNNING),
        .count  (wdog_count),
        .expire (wdog_expire)
    );

    // A zero count marks the first RUNNING cycle, where HALTED may still be stale.
    assign halt_seen = halted && (wdog_count != '0);
    assign busy      = (state != ST_IDLE);
    assign reg_raddr = idx;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        mem_we     = 1'b0;
        proc_init  = 1'b0;
        proc_en    = 1'b0;
        dump_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        CMD_WRITE: state_nxt = ST_WRITE;
                        CMD_RUN:   state_nxt = ST_INIT;
                        CMD_DUMP:  state_nxt = ST_RD_REQ;
                        default:   state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_INIT: begin
                proc_init = 1'b1;
                state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                proc_en = 1'b1;
                if (halt_seen || wdog_expire) state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                dump_valid = 1'b1;
                if (dump_ready) state_nxt = dump_last ? ST_IDLE : ST_RD_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            idx       <= '0;
            dump_data <= '0;
            dump_idx  <= '0;
            dump_last <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_op == CMD_WRITE) begin
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_data;
                    end
                    if (cmd_valid && cmd_op == CMD_DUMP) idx <= '0;
                end
                ST_INIT: timeout <= 1'b0;
                ST_RUNNING: begin
                    // Halt takes priority over a simultaneous watchdog expiry.
                    if (halt_seen) begin
                        idx <= '0;
                    end else if (wdog_expire) begin
                        idx     <= '0;
                        timeout <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    dump_data <= reg_rdata;
                    dump_idx  <= idx;
                    dump_last <= (idx == LAST_IDX);
                end
                ST_DUMP_OUT: begin
                    if (dump_ready && !dump_last) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_debug_loader.sv
// tb/tb_mips32_debug_loader.sv - directed scoreboard bench for mips32_debug_loader
module tb_mips32_debug_loader;
    import mips32_dbg_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int REG_AW   = 5;
    localparam int NUM_DUMP = 6;
    localparam int WDOG     = 16;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              proc_init;
    logic              proc_en;
    logic              halted;
    logic [REG_AW-1:0] reg_raddr;
    logic [31:0]       reg_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic [REG_AW-1:0] dump_idx;
    logic              dump_last;
    logic              busy;
    logic              timeout;

    always #5 clk1 = ~clk1;

    mips32_debug_loader #(
        .ADDR_W      (ADDR_W),
        .REG_AW      (REG_AW),
        .NUM_DUMP    (NUM_DUMP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .proc_init  (proc_init),
        .proc_en    (proc_en),
        .halted     (halted),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last),
        .busy       (busy),
        .timeout    (timeout)
    );

    typedef struct packed {
        logic [REG_AW-1:0] idx;
        logic [31:0]       data;
        logic              last;
    } dump_t;

    logic [31:0]          rf [0:31];
    dump_t                dump_q [$];
    logic [ADDR_W+31:0]   wr_q [$];
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;
    int                   we_cnt = 0;

    always @(posedge clk1) begin
        cyc       <= cyc + 1;
        reg_rdata <= rf[reg_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write scoreboard: every mem_we cycle must match the oldest pending WRITE.
    always @(negedge clk1) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            logic [ADDR_W+31:0] e;
            we_cnt++;
            chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int n = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < NUM_DUMP; i++)
            dump_q.push_back('{idx: REG_AW'(i), data: rf[i], last: (i == NUM_DUMP - 1)});
    endtask

    task automatic collect_dump(input int nwords, input int stall);
        dump_t e;
        for (int w = 0; w < nwords; w++) begin
            int n = 0;
            while (dump_valid !== 1'b1 && n < 10) begin step(); n++; end
            chk("dump_valid_wait", 32'(dump_valid), 32'd1);
            chk("dump_q_pending", 32'(dump_q.size() != 0), 32'd1);
            if (dump_q.size() != 0) e = dump_q.pop_front();
            for (int s = 0; s < stall; s++) begin
                step();
                chk("stall_valid", 32'(dump_valid), 32'd1);
                chk("stall_data", dump_data, e.data);
                chk("stall_idx", 32'(dump_idx), 32'(e.idx));
            end
            dump_ready = 1'b1;
            chk("dump_data", dump_data, e.data);
            chk("dump_idx", 32'(dump_idx), 32'(e.idx));
            chk("dump_last", 32'(dump_last), 32'(e.last));
            step();
            dump_ready = 1'b0;
        end
    endtask

    task automatic do_run(input int halt_cyc, input bit stale, input int exp_cycles, input bit exp_timeout);
        int en = 0;
        issue_cmd(CMD_RUN, '0, '0);
        chk("init_pulse", 32'(proc_init), 32'd1);
        chk("init_en", 32'(proc_en), 32'd0);
        step();
        chk("init_done", 32'(proc_init), 32'd0);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        while (proc_en === 1'b1 && en < 60) begin
            en++;
            halted = (en == 1 && stale) || (halt_cyc != 0 && en >= halt_cyc);
            step();
        end
        halted = 1'b0;
        chk("run_cycles", 32'(en), 32'(exp_cycles));
        chk("run_timeout", 32'(timeout), 32'(exp_timeout));
        chk("run_to_dump_busy", 32'(busy), 32'd1);
    endtask

    logic [31:0] prog [0:8];
    int          c0, c1;

    initial begin
        prog = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, {HLT_OPCODE, 26'd0}};
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = CMD_NOP; cmd_addr = '0; cmd_data = '0;
        halted = 1'b0; dump_ready = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outputs", 32'({mem_we, proc_init, proc_en, dump_valid, busy, timeout, dump_last}), 32'd0);
        chk("rst_data", dump_data | mem_wdata | 32'(reg_raddr) | 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Program load: nine back-to-back writes.
        for (int i = 0; i < 9; i++) begin
            wr_q.push_back({ADDR_W'(i), prog[i]});
            issue_cmd(CMD_WRITE, ADDR_W'(i), prog[i]);
            chk("we_after_accept", 32'(mem_we), 32'd1);
            if (i == 0) c0 = cyc;
            if (i == 8) c1 = cyc;
        end
        step();
        chk("we_single_cycle", 32'(mem_we), 32'd0);
        chk("load_cycles", 32'(c1 - c0 + 2), 32'd18);
        chk("we_count", 32'(we_cnt), 32'd9);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("mem_addr_hold", 32'(mem_addr), 32'd8);
        chk("mem_wdata_hold", mem_wdata, 32'hfc000000);

        issue_cmd(CMD_NOP, '0, '0);
        chk("nop_idle", 32'({busy, cmd_ready, mem_we}), 32'b010);

        // Full run: core halts in its 9th RUNNING cycle.
        rf[0] = 0; rf[1] = 10; rf[2] = 20; rf[3] = 30; rf[4] = 30; rf[5] = 60;
        push_dump();
        do_run(9, 1'b0, 9, 1'b0);
        collect_dump(NUM_DUMP, 0);
        chk("full_drained", 32'(dump_q.size()), 32'd0);
        chk("full_idle", 32'({busy, cmd_ready}), 32'b01);

        // Backpressure with Rk = k and the 2-cycle read latency.
        for (int i = 0; i < NUM_DUMP; i++) rf[i] = 32'(i);
        push_dump();
        issue_cmd(CMD_DUMP, '0, '0);
        chk("lat_rd_req", 32'({dump_valid, proc_en}), 32'd0);
        step();
        chk("lat_rd_wait", 32'(dump_valid), 32'd0);
        step();
        chk("lat_dump_out", 32'(dump_valid), 32'd1);
        collect_dump(NUM_DUMP, 3);
        chk("bp_drained", 32'(dump_q.size()), 32'd0);

        // Watchdog expiry, then a clean run clears the sticky timeout.
        for (int i = 0; i < NUM_DUMP; i++) rf[i] = 32'ha5000000 + 32'(i);
        push_dump();
        do_run(0, 1'b0, WDOG, 1'b1);
        collect_dump(NUM_DUMP, 1);
        chk("timeout_sticky", 32'(timeout), 32'd1);
        push_dump();
        do_run(5, 1'b0, 5, 1'b0);
        collect_dump(NUM_DUMP, 0);

        // Halt on the expiry cycle wins.
        push_dump();
        do_run(WDOG, 1'b0, WDOG, 1'b0);
        collect_dump(NUM_DUMP, 0);

        // Stale halt in cycle 1 ignored, real halt in cycle 3.
        push_dump();
        do_run(3, 1'b1, 3, 1'b0);
        collect_dump(NUM_DUMP, 0);

        // Asynchronous reset while idx 2 is on offer.
        push_dump();
        issue_cmd(CMD_DUMP, '0, '0);
        collect_dump(2, 0);
        begin
            int n = 0;
            while (dump_valid !== 1'b1 && n < 10) begin step(); n++; end
        end
        chk("pre_rst_idx", 32'(dump_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({dump_valid, proc_en, busy}), 32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        dump_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        push_dump();
        issue_cmd(CMD_DUMP, '0, '0);
        chk("restart_raddr", 32'(reg_raddr), 32'd0);
        collect_dump(NUM_DUMP, 0);
        chk("restart_drained", 32'(dump_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
